// File: rtl/ccd_sequencer.sv
// Frame sequencer for a CCD camera: flush passes, timed shutter exposure and a
// single readout pass, handshaking each pass with ccd_readout via toggle/busy.
module ccd_sequencer #(
  parameter int unsigned EXP_W   = 24,
  parameter int unsigned FLUSH_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [FLUSH_W-1:0] cmd_flushes,
  input  logic [EXP_W-1:0]   cmd_exposure,
  input  logic               cmd_binning,
  input  logic               tick,
  input  logic               abort,
  output logic               ro_toggle,
  output logic [1:0]         ro_mode,
  input  logic               ro_busy,
  output logic               shutter,
  output logic               frame_done,
  output logic               aborted,
  output logic [2:0]         seq_state
);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    FLUSH_START = 3'd1,
    FLUSH_WAIT  = 3'd2,
    EXPOSE      = 3'd3,
    READ_START  = 3'd4,
    READ_WAIT   = 3'd5,
    DONE        = 3'd6
  } state_t;

  state_t             state, state_nx;
  logic [FLUSH_W-1:0] flush_cnt, flush_cnt_nx;
  logic [EXP_W-1:0]   exp_cnt, exp_cnt_nx;
  logic               binning, binning_nx;
  logic               abort_pending, abort_pending_nx;
  logic               abort_evt;
  logic               accept;

  assign cmd_ready = (state == IDLE) && !ro_busy && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign seq_state = state;

  always_comb begin
    state_nx         = state;
    flush_cnt_nx     = flush_cnt;
    exp_cnt_nx       = exp_cnt;
    binning_nx       = binning;
    abort_pending_nx = abort_pending;
    abort_evt        = 1'b0;
    ro_toggle        = 1'b0;
    ro_mode          = 2'd0;
    frame_done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          flush_cnt_nx = cmd_flushes;
          exp_cnt_nx   = cmd_exposure;
          binning_nx   = cmd_binning;
          if (cmd_flushes != '0)       state_nx = FLUSH_START;
          else if (cmd_exposure != '0) state_nx = EXPOSE;
          else                         state_nx = READ_START;
        end
      end
      FLUSH_START: begin
        ro_toggle = 1'b1;
        ro_mode   = 2'd1;
        if (abort)   abort_pending_nx = 1'b1;
        if (ro_busy) state_nx = FLUSH_WAIT;
      end
      FLUSH_WAIT: begin
        ro_mode = 2'd1;
        if (abort) abort_pending_nx = 1'b1;
        if (!ro_busy) begin
          // An abort seen during the pass only takes effect once the pass ends
          if (abort_pending || abort) begin
            abort_evt        = 1'b1;
            abort_pending_nx = 1'b0;
            state_nx         = IDLE;
          end else begin
            if (flush_cnt != '0) flush_cnt_nx = flush_cnt - FLUSH_W'(1);
            if (flush_cnt > FLUSH_W'(1)) state_nx = FLUSH_START;
            else if (exp_cnt != '0)      state_nx = EXPOSE;
            else                         state_nx = READ_START;
          end
        end
      end
      EXPOSE: begin
        if (abort) begin
          abort_evt = 1'b1;
          state_nx  = IDLE;
        end else if (tick && exp_cnt != '0) begin
          exp_cnt_nx = exp_cnt - EXP_W'(1);
          if (exp_cnt == EXP_W'(1)) state_nx = READ_START;
        end
      end
      READ_START: begin
        ro_toggle = 1'b1;
        ro_mode   = {1'b1, binning};
        if (abort)   abort_pending_nx = 1'b1;
        if (ro_busy) state_nx = READ_WAIT;
      end
      READ_WAIT: begin
        ro_mode = {1'b1, binning};
        if (abort) abort_pending_nx = 1'b1;
        if (!ro_busy) begin
          if (abort_pending || abort) begin
            abort_evt        = 1'b1;
            abort_pending_nx = 1'b0;
            state_nx         = IDLE;
          end else begin
            state_nx = DONE;
          end
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flush_cnt     <= '0;
      exp_cnt       <= '0;
      binning       <= 1'b0;
      abort_pending <= 1'b0;
      shutter       <= 1'b0;
      aborted       <= 1'b0;
    end else begin
      state         <= state_nx;
      flush_cnt     <= flush_cnt_nx;
      exp_cnt       <= exp_cnt_nx;
      binning       <= binning_nx;
      abort_pending <= abort_pending_nx;
      shutter       <= (state_nx == EXPOSE);
      aborted       <= abort_evt;
    end
  end

endmodule

// File: tb/tb_ccd_sequencer.sv
// Self-checking bench for ccd_sequencer with a 20-cycle ccd_readout busy model
// and an event-level reference of what each frame must produce.
`timescale 1ns/1ps
module tb_ccd_sequencer;
  localparam int EXP_W   = 24;
  localparam int FLUSH_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [FLUSH_W-1:0] cmd_flushes = '0;
  logic [EXP_W-1:0]   cmd_exposure = '0;
  logic               cmd_binning = 1'b0;
  logic               tick = 1'b0;
  logic               abort = 1'b0;
  logic               ro_toggle;
  logic [1:0]         ro_mode;
  logic               ro_busy = 1'b0;
  logic               shutter;
  logic               frame_done;
  logic               aborted;
  logic [2:0]         seq_state;

  int errors = 0;
  int checks = 0;
  bit tick_en = 1'b0;

  ccd_sequencer #(.EXP_W(EXP_W), .FLUSH_W(FLUSH_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_flushes(cmd_flushes), .cmd_exposure(cmd_exposure), .cmd_binning(cmd_binning),
    .tick(tick), .abort(abort), .ro_toggle(ro_toggle), .ro_mode(ro_mode),
    .ro_busy(ro_busy), .shutter(shutter), .frame_done(frame_done),
    .aborted(aborted), .seq_state(seq_state)
  );

  always #5 clk = ~clk;

  // Readout model: busy rises one cycle after a toggle is seen, stays high 20 cycles
  int busy_left = 0;
  bit pend = 1'b0;
  always @(posedge clk) begin
    if (busy_left != 0) begin
      busy_left <= busy_left - 1;
      ro_busy   <= (busy_left != 1);
    end else if (pend) begin
      pend      <= 1'b0;
      ro_busy   <= 1'b1;
      busy_left <= 20;
    end else if (ro_toggle && !ro_busy) begin
      pend <= 1'b1;
    end
  end

  // Event monitor: cumulative counts; tasks compare deltas
  logic [1:0] modes[$];
  int shut_ticks = 0, opens = 0, dones = 0, aborts = 0, glitches = 0;
  logic p_tog = 1'b0, p_shut = 1'b0, p_busy = 1'b0, p_rst = 1'b1;
  logic [1:0] p_mode = 2'd0;
  always @(negedge clk) begin
    if (!rst) begin
      if (ro_toggle && !p_tog) modes.push_back(ro_mode);
      if (tick && shutter)     shut_ticks <= shut_ticks + 1;
      if (shutter && !p_shut)  opens <= opens + 1;
      if (frame_done)          dones <= dones + 1;
      if (aborted)             aborts <= aborts + 1;
      if (ro_busy && p_busy && !p_rst && ro_mode != p_mode) glitches <= glitches + 1;
    end
    p_tog  <= ro_toggle;
    p_shut <= shutter;
    p_busy <= ro_busy;
    p_rst  <= rst;
    p_mode <= ro_mode;
  end

  task automatic step();
    @(posedge clk); #1;
    tick = tick_en ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic offer(input int f, input int e, input int b, input string name);
    for (int i = 0; i < 200 && cmd_ready !== 1'b1; i++) step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s ready: got %b want 1", name, cmd_ready);
    end
    cmd_flushes  = FLUSH_W'(f);
    cmd_exposure = EXP_W'(e);
    cmd_binning  = b[0];
    cmd_valid    = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    checks++;
    if ({seq_state, ro_toggle, ro_mode, shutter, frame_done, aborted} !== 9'b0) begin
      errors++;
      $display("FAIL reset outputs: state=%0d tog=%b mode=%0d shut=%b done=%b abt=%b want all 0",
               seq_state, ro_toggle, ro_mode, shutter, frame_done, aborted);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset ready: got %b want 1", cmd_ready); end
  endtask

  task automatic run_frame(input int f, input int e, input int b, input string name);
    int q0, t0, o0, d0, a0, g0, first;
    bit got, bad;
    tick_en = 1'b1;
    q0 = modes.size(); t0 = shut_ticks; o0 = opens; d0 = dones; a0 = aborts; g0 = glitches;
    offer(f, e, b, name);
    first = (f != 0) ? 1 : (e != 0) ? 3 : 4;
    checks++;
    if (seq_state !== 3'(first)) begin
      errors++; $display("FAIL %s first_state: got %0d want %0d", name, seq_state, first);
    end
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      step();
      if (frame_done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL %s frame_done timeout: got 0 want 1", name); end
    step();
    tick_en = 1'b0;
    checks++;
    if (seq_state !== 3'd0) begin errors++; $display("FAIL %s end_state: got %0d want 0", name, seq_state); end
    checks++;
    if (modes.size() - q0 !== f + 1) begin
      errors++; $display("FAIL %s toggles: got %0d want %0d", name, modes.size() - q0, f + 1);
    end else begin
      bad = 1'b0;
      for (int k = 0; k <= f; k++)
        if (modes[q0 + k] !== ((k < f) ? 2'd1 : 2'(2 + b))) bad = 1'b1;
      checks++;
      if (bad) begin errors++; $display("FAIL %s toggle_modes: got wrong sequence want %0d x1 then %0d", name, f, 2 + b); end
    end
    checks++;
    if (shut_ticks - t0 !== e) begin errors++; $display("FAIL %s shutter_ticks: got %0d want %0d", name, shut_ticks - t0, e); end
    checks++;
    if (opens - o0 !== ((e != 0) ? 1 : 0)) begin errors++; $display("FAIL %s shutter_opens: got %0d want %0d", name, opens - o0, (e != 0) ? 1 : 0); end
    checks++;
    if (dones - d0 !== 1 || aborts - a0 !== 0) begin
      errors++; $display("FAIL %s done/aborted: got %0d/%0d want 1/0", name, dones - d0, aborts - a0);
    end
    checks++;
    if (glitches - g0 !== 0) begin errors++; $display("FAIL %s mode_while_busy: got %0d changes want 0", name, glitches - g0); end
  endtask

  task automatic test_abort_expose();
    int q0, a0;
    tick_en = 1'b0;
    q0 = modes.size(); a0 = aborts;
    offer(0, 5, 0, "abort_expose");
    checks++;
    if (seq_state !== 3'd3 || shutter !== 1'b1) begin
      errors++; $display("FAIL abort_expose entry: got state=%0d shut=%b want 3/1", seq_state, shutter);
    end
    tick = 1'b1;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    checks++;
    if (shutter !== 1'b0 || aborted !== 1'b1 || seq_state !== 3'd0) begin
      errors++; $display("FAIL abort_expose effect: got shut=%b abt=%b state=%0d want 0/1/0", shutter, aborted, seq_state);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_expose ready: got %b want 1", cmd_ready); end
    step();
    checks++;
    if (aborted !== 1'b0) begin errors++; $display("FAIL abort_expose pulse_width: got %b want 0", aborted); end
    checks++;
    if (modes.size() !== q0 || aborts - a0 !== 1) begin
      errors++; $display("FAIL abort_expose events: got toggles=%0d aborts=%0d want 0/1", modes.size() - q0, aborts - a0);
    end
  endtask

  task automatic test_tick_abort_same();
    int q0;
    tick_en = 1'b0;
    q0 = modes.size();
    offer(0, 1, 0, "tick_abort");
    tick  = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    checks++;
    if (seq_state !== 3'd0 || aborted !== 1'b1 || ro_toggle !== 1'b0) begin
      errors++; $display("FAIL tick_abort priority: got state=%0d abt=%b tog=%b want 0/1/0", seq_state, aborted, ro_toggle);
    end
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (modes.size() !== q0) begin errors++; $display("FAIL tick_abort toggles: got %0d want 0", modes.size() - q0); end
  endtask

  task automatic test_abort_flush();
    int q0, o0, d0, a0, bad;
    bit got;
    tick_en = 1'b0;
    q0 = modes.size(); o0 = opens; d0 = dones; a0 = aborts;
    offer(3, 2, 0, "abort_flush");
    for (int i = 0; i < 100 && seq_state !== 3'd2; i++) step();
    checks++;
    if (seq_state !== 3'd2) begin errors++; $display("FAIL abort_flush reach_wait: got %0d want 2", seq_state); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    bad = 0;
    for (int i = 0; i < 100 && ro_busy === 1'b1; i++) begin
      if (ro_mode !== 2'd1 || aborted === 1'b1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL abort_flush held_mode: got %0d bad cycles want 0", bad); end
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (aborted === 1'b1) got = 1'b1; else step();
    end
    checks++;
    if (!got || seq_state !== 3'd0) begin
      errors++; $display("FAIL abort_flush aborted: got pulse=%b state=%0d want 1/0", got, seq_state);
    end
    for (int i = 0; i < 30; i++) step();
    checks++;
    if (modes.size() - q0 !== 1 || opens - o0 !== 0 || dones - d0 !== 0 || aborts - a0 !== 1) begin
      errors++; $display("FAIL abort_flush events: got tog=%0d opens=%0d done=%0d abt=%0d want 1/0/0/1",
                         modes.size() - q0, opens - o0, dones - d0, aborts - a0);
    end
  endtask

  task automatic test_reset_read_wait();
    int d0, bad;
    tick_en = 1'b0;
    d0 = dones;
    offer(0, 0, 0, "reset_read");
    for (int i = 0; i < 20 && seq_state !== 3'd5; i++) step();
    checks++;
    if (seq_state !== 3'd5) begin errors++; $display("FAIL reset_read reach_wait: got %0d want 5", seq_state); end
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({seq_state, ro_toggle, ro_mode, shutter, frame_done, aborted} !== 9'b0) begin
      errors++;
      $display("FAIL reset_read outputs: state=%0d tog=%b mode=%0d shut=%b done=%b abt=%b want all 0",
               seq_state, ro_toggle, ro_mode, shutter, frame_done, aborted);
    end
    bad = 0;
    for (int i = 0; i < 40 && ro_busy === 1'b1; i++) begin
      if (cmd_ready !== 1'b0) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_read ready_while_busy: got %0d high cycles want 0", bad); end
    checks++;
    if (ro_busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_read ready_after: got busy=%b ready=%b want 0/1", ro_busy, cmd_ready);
    end
    step();
    checks++;
    if (dones - d0 !== 0) begin errors++; $display("FAIL reset_read frame_done: got %0d want 0", dones - d0); end
  endtask

  initial begin
    test_reset();
    run_frame(2, 3, 0, "frame_2_3_0");
    run_frame(0, 0, 1, "frame_0_0_1");
    test_abort_expose();
    test_abort_flush();
    test_reset_read_wait();
    test_tick_abort_same();
    for (int n = 0; n < 6; n++)
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), int'($urandom_range(0, 1)), "random");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
